// File: rtl/flush_sequencer.sv
// rtl/flush_sequencer.sv - pipeline recovery sequencer: flush, DMEM drain, fetch redirect
//
// Ports:
//   clk, rst                  core clock, asynchronous active-low reset
//   redirect_req_val/rdy/pc/is_trap   recovery request from ROB commit
//   dmem_req_fire, dmem_rec_fire      DMEM request/response handshakes
//   dmem_req_allow            gate for DMEM request ready
//   flush, dmem_rec_discard   registered pipeline flush / response squash
//   pc_sel, rob_pc            registered one-cycle fetch redirect
//   busy, outstanding, err_underflow  status
module flush_sequencer #(
    parameter int CPU_ADDR_BITS   = 32,
    parameter int FLUSH_CYCLES    = 2,
    parameter int MAX_OUTSTANDING = 4,
    localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_req_val,
    output logic                     redirect_req_rdy,
    input  logic [CPU_ADDR_BITS-1:0] redirect_req_pc,
    input  logic                     redirect_req_is_trap,
    input  logic                     dmem_req_fire,
    input  logic                     dmem_rec_fire,
    output logic                     dmem_req_allow,
    output logic                     flush,
    output logic                     dmem_rec_discard,
    output logic [2:0]               pc_sel,
    output logic [CPU_ADDR_BITS-1:0] rob_pc,
    output logic                     busy,
    output logic [OW-1:0]            outstanding,
    output logic                     err_underflow
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_DRAIN    = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

    state_t                   state, state_nxt;
    logic [3:0]               fcnt, fcnt_nxt;
    logic [OW-1:0]            out_nxt;
    logic                     underflow_hit;
    logic [CPU_ADDR_BITS-1:0] pc_lat;
    logic                     trap_lat;
    logic                     accept;

    assign redirect_req_rdy = (state == S_IDLE);
    assign busy             = (state != S_IDLE);
    assign dmem_req_allow   = (state == S_IDLE) && (outstanding < MAX_CNT);
    assign accept           = redirect_req_val && redirect_req_rdy;

    // In-flight DMEM count; simultaneous req+rec cancel, including at zero.
    always_comb begin
        out_nxt       = outstanding;
        underflow_hit = 1'b0;
        if (dmem_req_fire && !dmem_rec_fire) begin
            if (outstanding != MAX_CNT)
                out_nxt = outstanding + OW'(1);
        end else if (dmem_rec_fire && !dmem_req_fire) begin
            if (outstanding == '0)
                underflow_hit = 1'b1;
            else
                out_nxt = outstanding - OW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_FLUSH;
                    fcnt_nxt  = 4'(FLUSH_CYCLES - 1);
                end
            end
            S_FLUSH: begin
                if (fcnt == 4'd0)
                    state_nxt = (outstanding != '0) ? S_DRAIN : S_REDIRECT;
                else
                    fcnt_nxt = fcnt - 4'd1;
            end
            S_DRAIN: begin
                // A response retiring the last op this cycle already completes the drain.
                if (outstanding == '0 || out_nxt == '0)
                    state_nxt = S_REDIRECT;
            end
            S_REDIRECT: state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_IDLE;
            fcnt             <= 4'd0;
            outstanding      <= '0;
            err_underflow    <= 1'b0;
            pc_lat           <= '0;
            trap_lat         <= 1'b0;
            flush            <= 1'b0;
            dmem_rec_discard <= 1'b0;
            pc_sel           <= 3'b000;
            rob_pc           <= '0;
        end else begin
            state            <= state_nxt;
            fcnt             <= fcnt_nxt;
            outstanding      <= out_nxt;
            if (underflow_hit)
                err_underflow <= 1'b1;
            if (accept) begin
                pc_lat   <= redirect_req_pc;
                trap_lat <= redirect_req_is_trap;
            end
            flush            <= (state_nxt == S_FLUSH);
            dmem_rec_discard <= (state_nxt == S_FLUSH) || (state_nxt == S_DRAIN);
            if (state_nxt == S_REDIRECT) begin
                pc_sel <= trap_lat ? 3'b010 : 3'b001;
                rob_pc <= pc_lat;
            end else begin
                pc_sel <= 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_flush_sequencer.sv
// tb/tb_flush_sequencer.sv - self-checking bench for flush_sequencer
module tb_flush_sequencer;

    localparam int AW = 32;
    localparam int FC = 2;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          val, trap, req, rec;
    logic [AW-1:0] pc;

    logic          rdy, allow, flush, disc, busy, err;
    logic [2:0]    pc_sel;
    logic [AW-1:0] rob_pc;
    logic [2:0]    outst;

    logic          rdy1, allow1, flush1, disc1, busy1, err1;
    logic [2:0]    pc_sel1;
    logic [AW-1:0] rob_pc1;
    logic [2:0]    outst1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flush_sequencer #(.CPU_ADDR_BITS(AW), .FLUSH_CYCLES(FC), .MAX_OUTSTANDING(MAXO)) u_dut (
        .clk(clk), .rst(rst),
        .redirect_req_val(val), .redirect_req_rdy(rdy),
        .redirect_req_pc(pc), .redirect_req_is_trap(trap),
        .dmem_req_fire(req), .dmem_rec_fire(rec), .dmem_req_allow(allow),
        .flush(flush), .dmem_rec_discard(disc), .pc_sel(pc_sel), .rob_pc(rob_pc),
        .busy(busy), .outstanding(outst), .err_underflow(err)
    );

    flush_sequencer #(.CPU_ADDR_BITS(AW), .FLUSH_CYCLES(1), .MAX_OUTSTANDING(MAXO)) u_dut1 (
        .clk(clk), .rst(rst),
        .redirect_req_val(val), .redirect_req_rdy(rdy1),
        .redirect_req_pc(pc), .redirect_req_is_trap(trap),
        .dmem_req_fire(req), .dmem_rec_fire(rec), .dmem_req_allow(allow1),
        .flush(flush1), .dmem_rec_discard(disc1), .pc_sel(pc_sel1), .rob_pc(rob_pc1),
        .busy(busy1), .outstanding(outst1), .err_underflow(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic apply(input logic v, input logic [AW-1:0] p, input logic t,
                         input logic rq, input logic rc);
        val = v; pc = p; trap = t; req = rq; rec = rc;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; val = 0; pc = '0; trap = 0; req = 0; rec = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        logic          v;
        logic [AW-1:0] p;
        logic          t, rq, rc;
        logic          e_flush;
        logic [2:0]    e_sel;
        logic          e_rdy;
        logic [2:0]    e_out;
        logic          e_allow, e_disc, e_err;
        logic [AW-1:0] e_rob;
        logic          e1_flush;
        logic [2:0]    e1_sel;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [AW-1:0] p, logic t, logic rq, logic rc,
                                logic f, logic [2:0] s, logic r, logic [2:0] o, logic a,
                                logic d, logic e, logic [AW-1:0] rb, logic f1, logic [2:0] s1);
        vec_t x;
        x.v = v; x.p = p; x.t = t; x.rq = rq; x.rc = rc;
        x.e_flush = f; x.e_sel = s; x.e_rdy = r; x.e_out = o; x.e_allow = a;
        x.e_disc = d; x.e_err = e; x.e_rob = rb; x.e1_flush = f1; x.e1_sel = s1;
        return x;
    endfunction

    // Reference model state: remaining flush cycles, drain flag, redirect flag.
    int            m_out, m_flush_left;
    bit            m_drain, m_redir, m_err, m_trap;
    logic [AW-1:0] m_pc, m_rob;

    task automatic model_reset();
        m_out = 0; m_flush_left = 0; m_drain = 0; m_redir = 0; m_err = 0;
        m_trap = 0; m_pc = '0; m_rob = '0;
    endtask

    task automatic model_check();
        bit mbusy;
        mbusy = (m_flush_left > 0) || m_drain || m_redir;
        check("r_flush", flush, m_flush_left > 0);
        check("r_disc", disc, (m_flush_left > 0) || m_drain);
        check("r_pc_sel", pc_sel, m_redir ? (m_trap ? 3'b010 : 3'b001) : 3'b000);
        check("r_rob_pc", rob_pc, m_rob);
        check("r_busy", busy, mbusy);
        check("r_rdy", rdy, !mbusy);
        check("r_allow", allow, !mbusy && (m_out < MAXO));
        check("r_out", outst, m_out);
        check("r_err", err, m_err);
    endtask

    task automatic model_step(input bit v, input logic [AW-1:0] p, input bit t,
                              input bit rq, input bit rc);
        int  n_out;
        bit  mbusy;
        mbusy = (m_flush_left > 0) || m_drain || m_redir;
        n_out = m_out;
        if (rq && !rc)      n_out = (m_out + 1 > MAXO) ? MAXO : m_out + 1;
        else if (rc && !rq) begin
            if (m_out == 0) m_err = 1;
            else            n_out = m_out - 1;
        end
        if (!mbusy && v) begin
            m_flush_left = FC; m_pc = p; m_trap = t;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0) begin
                if (m_out != 0) m_drain = 1;
                else begin m_redir = 1; m_rob = m_pc; end
            end
        end else if (m_drain) begin
            if (m_out == 0 || n_out == 0) begin
                m_drain = 0; m_redir = 1; m_rob = m_pc;
            end
        end else if (m_redir) begin
            m_redir = 0;
        end
        m_out = n_out;
    endtask

    initial begin
        // Reset then idle
        do_reset();
        @(negedge clk);
        check("rst_flush", flush, 0);
        check("rst_pc_sel", pc_sel, 0);
        check("rst_rob_pc", rob_pc, 0);
        check("rst_disc", disc, 0);
        check("rst_busy", busy, 0);
        check("rst_out", outst, 0);
        check("rst_err", err, 0);
        check("rst_rdy", rdy, 1);
        check("rst_allow", allow, 1);
        next_cycle();

        // Mispredict, counter limits, underflow (table)
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 3'd0, 1, 3'd0, 1, 0, 0, 0,     0, 3'd0));
        vecs.push_back(mk(1, 'h100, 0, 0, 0, 0, 3'd0, 1, 3'd0, 1, 0, 0, 0,     0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 1, 3'd0, 0, 3'd0, 0, 1, 0, 0,     1, 3'd0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 1, 3'd0, 0, 3'd0, 0, 1, 0, 0,     0, 3'd1));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 3'd1, 0, 3'd0, 0, 0, 0, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 1, 0, 0, 3'd0, 1, 3'd0, 1, 0, 0, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 1, 0, 0, 3'd0, 1, 3'd1, 1, 0, 0, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 1, 0, 0, 3'd0, 1, 3'd2, 1, 0, 0, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 1, 0, 0, 3'd0, 1, 3'd3, 1, 0, 0, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 1, 1, 0, 3'd0, 1, 3'd4, 0, 0, 0, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 1, 0, 0, 3'd0, 1, 3'd4, 0, 0, 0, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 0, 1, 0, 3'd0, 1, 3'd4, 0, 0, 0, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 0, 1, 0, 3'd0, 1, 3'd3, 1, 0, 0, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 0, 1, 0, 3'd0, 1, 3'd2, 1, 0, 0, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 0, 1, 0, 3'd0, 1, 3'd1, 1, 0, 0, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 3'd0, 1, 3'd0, 1, 0, 0, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 0, 1, 0, 3'd0, 1, 3'd0, 1, 0, 0, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 1, 1, 0, 3'd0, 1, 3'd0, 1, 0, 1, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 3'd0, 1, 3'd0, 1, 0, 1, 'h100, 0, 3'd0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 3'd0, 1, 3'd0, 1, 0, 1, 'h100, 0, 3'd0));
        foreach (vecs[i]) begin
            apply(vecs[i].v, vecs[i].p, vecs[i].t, vecs[i].rq, vecs[i].rc);
            check($sformatf("v%0d_flush", i), flush, vecs[i].e_flush);
            check($sformatf("v%0d_pc_sel", i), pc_sel, vecs[i].e_sel);
            check($sformatf("v%0d_rdy", i), rdy, vecs[i].e_rdy);
            check($sformatf("v%0d_busy", i), busy, !vecs[i].e_rdy);
            check($sformatf("v%0d_out", i), outst, vecs[i].e_out);
            check($sformatf("v%0d_allow", i), allow, vecs[i].e_allow);
            check($sformatf("v%0d_disc", i), disc, vecs[i].e_disc);
            check($sformatf("v%0d_err", i), err, vecs[i].e_err);
            check($sformatf("v%0d_rob_pc", i), rob_pc, vecs[i].e_rob);
            if (i <= 4) begin
                check($sformatf("v%0d_fc1_flush", i), flush1, vecs[i].e1_flush);
                check($sformatf("v%0d_fc1_pc_sel", i), pc_sel1, vecs[i].e1_sel);
            end
            next_cycle();
        end

        // Trap with drain; requester keeps val high while busy
        do_reset();
        apply(0, 0, 0, 1, 0);              check("td_out0", outst, 0);     next_cycle();
        apply(0, 0, 0, 1, 0);              check("td_out1", outst, 1);     next_cycle();
        apply(1, 32'h8000_0000, 1, 0, 0);  check("td_rdy", rdy, 1);        next_cycle();
        apply(1, 32'h1234_0000, 0, 0, 0);
        check("td_f1_flush", flush, 1); check("td_f1_rdy", rdy, 0); check("td_f1_disc", disc, 1);
        next_cycle();
        apply(0, 0, 0, 0, 0);              check("td_f2_flush", flush, 1); next_cycle();
        apply(0, 0, 0, 0, 0);
        check("td_d_flush", flush, 0); check("td_d_disc", disc, 1);
        check("td_d_busy", busy, 1); check("td_d_sel", pc_sel, 0); check("td_d_out", outst, 2);
        next_cycle();
        apply(0, 0, 0, 0, 1);              check("td_d2_disc", disc, 1);   next_cycle();
        apply(0, 0, 0, 0, 1);
        check("td_d3_disc", disc, 1); check("td_d3_out", outst, 1); check("td_d3_sel", pc_sel, 0);
        next_cycle();
        apply(0, 0, 0, 0, 0);
        check("td_r_sel", pc_sel, 3'b010); check("td_r_rob", rob_pc, 32'h8000_0000);
        check("td_r_out", outst, 0); check("td_r_disc", disc, 0); check("td_r_rdy", rdy, 0);
        next_cycle();
        apply(0, 0, 0, 0, 0);
        check("td_i_rdy", rdy, 1); check("td_i_sel", pc_sel, 0); check("td_i_rob", rob_pc, 32'h8000_0000);
        next_cycle();

        // Reset mid-DRAIN
        do_reset();
        apply(0, 0, 0, 1, 0); next_cycle();
        apply(0, 0, 0, 1, 0); next_cycle();
        apply(1, 32'h0000_4000, 0, 0, 0); next_cycle();
        apply(0, 0, 0, 0, 0); next_cycle();
        apply(0, 0, 0, 0, 0); next_cycle();
        apply(0, 0, 0, 0, 0);
        check("rd_pre_busy", busy, 1); check("rd_pre_out", outst, 2); check("rd_pre_disc", disc, 1);
        rst = 1'b0;
        #1;
        check("rd_busy", busy, 0); check("rd_out", outst, 0); check("rd_disc", disc, 0);
        check("rd_flush", flush, 0); check("rd_rdy", rdy, 1);
        next_cycle();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            apply(0, 0, 0, 0, 0);
            check($sformatf("rd_post%0d_sel", k), pc_sel, 0);
            check($sformatf("rd_post%0d_busy", k), busy, 0);
            next_cycle();
        end

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            bit            v, t, rq, rc;
            logic [AW-1:0] p;
            bit            mbusy;
            mbusy = (m_flush_left > 0) || m_drain || m_redir;
            v  = ($urandom_range(0, 5) == 0);
            t  = $urandom_range(0, 1);
            p  = $urandom;
            rq = (!mbusy && m_out < MAXO) ? ($urandom_range(0, 1) == 1) : 1'b0;
            rc = ($urandom_range(0, 2) == 0);
            apply(v, p, t, rq, rc);
            model_check();
            model_step(v, p, t, rq, rc);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
